// File: rtl/t_ff_toggle_seq_if.sv
// Command/status bundle between a control agent (master) and the toggle sequencer (slave).
interface t_ff_toggle_seq_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count;
  logic [GAP_W-1:0] cmd_gap;
  logic             abort;
  logic             toggle;
  logic             out;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] remaining;

  modport master (
    output cmd_valid, cmd_count, cmd_gap, abort,
    input  cmd_ready, toggle, out, busy, done, aborted, remaining
  );

  modport slave (
    input  cmd_valid, cmd_count, cmd_gap, abort,
    output cmd_ready, toggle, out, busy, done, aborted, remaining
  );
endinterface

// File: rtl/t_ff_toggle_seq.sv
// Toggle sequencer: issues a commanded number of single-cycle toggle strobes with a fixed
// idle gap between them, and mirrors the driven T flip-flop level on out.
module t_ff_toggle_seq #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned GAP_W     = 8,
  parameter int unsigned POR_VALUE = 1
) (
  input  logic               clk,
  input  logic               rst,
  t_ff_toggle_seq_if.slave   bus
);

  localparam logic POR_BIT = POR_VALUE[0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] rem_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gcnt_q;
  logic             toggle_q;
  logic             out_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;

  // State, counters and registered outputs all advance together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      gap_q     <= '0;
      gcnt_q    <= '0;
      toggle_q  <= 1'b0;
      out_q     <= POR_BIT;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      // The strobe issued this cycle lands in the flip-flop at this edge, abort or not.
      if (toggle_q) begin
        out_q <= ~out_q;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_count == '0) begin
              done_q <= 1'b1;
            end else begin
              rem_q    <= bus.cmd_count;
              gap_q    <= bus.cmd_gap;
              state_q  <= S_PULSE;
              toggle_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
        end

        S_PULSE: begin
          if (bus.abort) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            toggle_q  <= 1'b0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else if (rem_q == CNT_W'(1)) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            toggle_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            rem_q <= rem_q - CNT_W'(1);
            if (gap_q != '0) begin
              state_q  <= S_GAP;
              gcnt_q   <= gap_q;
              toggle_q <= 1'b0;
            end
          end
        end

        S_GAP: begin
          if (bus.abort) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else if (gcnt_q == GAP_W'(1)) begin
            state_q  <= S_PULSE;
            toggle_q <= 1'b1;
          end else begin
            gcnt_q <= gcnt_q - GAP_W'(1);
          end
        end

        default: begin
          state_q  <= S_IDLE;
          rem_q    <= '0;
          toggle_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.toggle    = toggle_q;
  assign bus.out       = out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.remaining = rem_q;

endmodule

// File: tb/tb_t_ff_toggle_seq.sv
// Bench for t_ff_toggle_seq: burst-position model checked every cycle plus directed literal checks.
module tb_t_ff_toggle_seq;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned GAP_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   cmp_en = 1'b0;

  t_ff_toggle_seq_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  t_ff_toggle_seq #(.CNT_W(CNT_W), .GAP_W(GAP_W), .POR_VALUE(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a burst is a position t within n + (n-1)*g busy cycles; toggles fall on multiples of g+1.
  bit m_active, m_out, m_done, m_aborted;
  int m_n, m_g, m_t;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0; m_out <= 1'b0; m_done <= 1'b0; m_aborted <= 1'b0;
      m_n <= 0; m_g <= 0; m_t <= 0;
    end else begin
      m_done    <= 1'b0;
      m_aborted <= 1'b0;
      if (m_active) begin
        if (m_t % (m_g + 1) == 0) m_out <= !m_out;
        if (bus.abort) begin
          m_active <= 1'b0; m_aborted <= 1'b1;
        end else if (m_t == m_n + (m_n - 1) * m_g - 1) begin
          m_active <= 1'b0; m_done <= 1'b1;
        end else begin
          m_t <= m_t + 1;
        end
      end else if (bus.cmd_valid) begin
        if (bus.cmd_count == '0) begin
          m_done <= 1'b1;
        end else begin
          m_active <= 1'b1;
          m_n <= int'(bus.cmd_count);
          m_g <= int'(bus.cmd_gap);
          m_t <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      chk("toggle",    bus.toggle,    32'(m_active && (m_t % (m_g + 1) == 0)));
      chk("busy",      bus.busy,      32'(m_active));
      chk("cmd_ready", bus.cmd_ready, 32'(!m_active));
      chk("done",      bus.done,      32'(m_done));
      chk("aborted",   bus.aborted,   32'(m_aborted));
      chk("out",       bus.out,       32'(m_out));
      chk("remaining", bus.remaining, 32'(m_active ? m_n - (m_t + m_g) / (m_g + 1) : 0));
    end
  end

  // Present a command for one accepting edge; returns at the negedge of the burst's first cycle.
  task automatic send(input int cnt, input int gap);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_count = CNT_W'(cnt);
    bus.cmd_gap   = GAP_W'(gap);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  logic [9:0] tg, dn, bz, ot, ab;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_count = '0;
    bus.cmd_gap   = '0;
    bus.abort     = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_toggle", bus.toggle, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_remaining", bus.remaining, 0);
    chk("rst_out", bus.out, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // count=3 gap=0: back-to-back toggles
    send(3, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      tg[i] = bus.toggle; dn[i] = bus.done; ot[i] = bus.out;
      if (i < 3) chk("t1_remaining", bus.remaining, 32'(3 - i));
    end
    chk("t1_toggle_pat", tg[7:0], 8'b0000_0111);
    chk("t1_done_pat",   dn[7:0], 8'b0000_1000);
    chk("t1_out_pat",    ot[7:0], 8'b1111_1010);

    // count=3 gap=2
    send(3, 2);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      tg[i] = bus.toggle; dn[i] = bus.done; bz[i] = bus.busy; ot[i] = bus.out;
    end
    chk("t2_toggle_pat", tg[7:0], 8'b0100_1001);
    chk("t2_busy_pat",   bz[7:0], 8'b0111_1111);
    chk("t2_done_pat",   dn[7:0], 8'b1000_0000);
    chk("t2_out_start",  ot[0], 1);
    chk("t2_out_end",    ot[7], 0);

    // count=0: done only, never busy
    send(0, 5);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      tg[i] = bus.toggle; dn[i] = bus.done; bz[i] = bus.busy;
    end
    chk("t3_done_pat",   dn[3:0], 4'b0001);
    chk("t3_busy_pat",   bz[3:0], 4'b0000);
    chk("t3_toggle_pat", tg[3:0], 4'b0000);

    // count=5 gap=3, abort in the gap after the second toggle
    send(5, 3);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      tg[i] = bus.toggle; dn[i] = bus.done; bz[i] = bus.busy; ot[i] = bus.out; ab[i] = bus.aborted;
      if (i == 6) chk("t4_remaining", bus.remaining, 0);
      if (i == 5) bus.abort = 1'b1;
      if (i == 6) bus.abort = 1'b0;
    end
    chk("t4_toggle_pat",  tg, 10'b00_0001_0001);
    chk("t4_aborted_pat", ab, 10'b00_0100_0000);
    chk("t4_done_pat",    dn, 10'b00_0000_0000);
    chk("t4_busy_pat",    bz, 10'b00_0011_1111);
    chk("t4_out_mid",     ot[4], 1);
    chk("t4_out_end",     ot[6], 0);

    // cmd_valid held during a burst is ignored; a command in the done cycle is taken
    send(2, 1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      tg[i] = bus.toggle; dn[i] = bus.done; bz[i] = bus.busy;
      if (i == 0) begin
        bus.cmd_valid = 1'b1; bus.cmd_count = CNT_W'(7); bus.cmd_gap = '0;
      end
      if (i == 3) bus.cmd_count = CNT_W'(2);
      if (i == 4) bus.cmd_valid = 1'b0;
    end
    chk("t5_toggle_pat", tg[8:0], 9'b0_0011_0101);
    chk("t5_done_pat",   dn[8:0], 9'b0_0100_1000);
    chk("t5_busy_pat",   bz[8:0], 9'b0_0011_0111);

    // async reset mid-PULSE, then a single toggle
    send(4, 0);
    @(negedge clk);
    chk("t6_pre_out", bus.out, 1);
    chk("t6_pre_toggle", bus.toggle, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_toggle", bus.toggle, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_remaining", bus.remaining, 0);
    chk("t6_rst_out", bus.out, 0);
    chk("t6_rst_ready", bus.cmd_ready, 1);
    chk("t6_rst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    send(1, 0);
    chk("t6_post_toggle", bus.toggle, 1);
    chk("t6_post_rem", bus.remaining, 1);
    chk("t6_post_out0", bus.out, 0);
    @(negedge clk);
    chk("t6_post_done", bus.done, 1);
    chk("t6_post_out1", bus.out, 1);
    chk("t6_post_busy", bus.busy, 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
